// File: rtl/mx2_rr_arbiter.sv
// Two-requester round-robin arbiter steering a shared 2:1 mux onto one registered
// output stream, holding each grant for bursts of up to MAX_BURST beats.
module mx2_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d0,
   input  logic             v0,
   output logic             r0,
   input  logic [WIDTH-1:0] d1,
   input  logic             v1,
   output logic             r1,
   output logic             s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic               sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               yValid_q, yValid_d;

   logic               free;
   logic               beat;
   logic               vCur;
   logic               vOther;
   logic               burstEnd;
   logic [WIDTH-1:0]   dCur;
   state_t             otherState;
   logic               otherIdx;

   always_comb begin
      free       = !yValid_q | y_ready;
      r0         = (state_q == G0) & free;
      r1         = (state_q == G1) & free;
      vCur       = (state_q == G1) ? v1 : v0;
      vOther     = (state_q == G1) ? v0 : v1;
      dCur       = (state_q == G1) ? d1 : d0;
      otherState = (state_q == G1) ? G0 : G1;
      otherIdx   = (state_q != G1);
      beat       = (r0 & v0) | (r1 & v1);
      burstEnd   = (cnt_q == CNT_W'(MAX_BURST - 1));

      state_d  = state_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      yValid_d = yValid_q;

      if (beat) begin
         y_d      = dCur;
         yValid_d = 1'b1;
         cnt_d    = cnt_q + CNT_W'(1);
      end else if (y_ready) begin
         yValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // A tie goes to whichever side did not hold the previous grant
            if (v0 && v1) begin
               state_d = last_q ? G0 : G1;
               last_d  = !last_q;
               cnt_d   = '0;
            end else if (v0) begin
               state_d = G0;
               last_d  = 1'b0;
               cnt_d   = '0;
            end else if (v1) begin
               state_d = G1;
               last_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         G0, G1: begin
            if (free && !vCur) begin
               if (vOther) begin
                  state_d = otherState;
                  last_d  = otherIdx;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (beat && burstEnd) begin
               // Burst exhausted: rotate only if the other side is waiting
               cnt_d = '0;
               if (vOther) begin
                  state_d = otherState;
                  last_d  = otherIdx;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == G1) begin
         sel_d = 1'b1;
      end else if (state_d == G0) begin
         sel_d = 1'b0;
      end else begin
         sel_d = sel_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         sel_q    <= 1'b0;
         cnt_q    <= '0;
         y_q      <= '0;
         yValid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         yValid_q <= yValid_d;
      end
   end

   assign s       = sel_q;
   assign y       = y_q;
   assign y_valid = yValid_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mx2_rr_arbiter.sv
// Directed bench for mx2_rr_arbiter: a default-burst instance and a MAX_BURST=1
// instance share clock and reset; each scenario task checks its own vectors.
module tb_mx2_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] d0, d1, y;
   logic       v0, v1, r0, r1, s, y_valid, y_ready, busy;
   logic [7:0] bd0, bd1, by;
   logic       bv0, bv1, br0, br1, bs, by_valid, by_ready, bbusy;

   int         nChecks = 0;
   int         nFail   = 0;
   logic [7:0] outQ[$];
   logic [7:0] boutQ[$];
   logic       fire0, fire1, bfire0, bfire1;
   logic       smpS, smpYValid, smpR0, smpR1;
   logic [7:0] smpY;

   always #5 clk = ~clk;

   mx2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .d0(d0), .v0(v0), .r0(r0),
      .d1(d1), .v1(v1), .r1(r1),
      .s(s), .y(y), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
   );

   mx2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1), .CNT_W(1)) dutB (
      .clk(clk), .reset_n(reset_n),
      .d0(bd0), .v0(bv0), .r0(br0),
      .d1(bd1), .v1(bv1), .r1(br1),
      .s(bs), .y(by), .y_valid(by_valid), .y_ready(by_ready), .busy(bbusy)
   );

   // Sample mid-cycle, log accepted output words, then step past the next rising edge
   task automatic tick();
      @(negedge clk);
      fire0     = v0 & r0;
      fire1     = v1 & r1;
      bfire0    = bv0 & br0;
      bfire1    = bv1 & br1;
      smpS      = s;
      smpY      = y;
      smpYValid = y_valid;
      smpR0     = r0;
      smpR1     = r1;
      if (y_valid && y_ready) outQ.push_back(y);
      if (by_valid && by_ready) boutQ.push_back(by);
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      reset_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; y_ready = 1'b0;
      bv0 = 1'b0; bv1 = 1'b0; bd0 = 8'h00; bd1 = 8'h00; by_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      outQ.delete();
      boutQ.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; y_ready = 1'b0;
      bv0 = 1'b0; bv1 = 1'b0; bd0 = 8'h00; bd1 = 8'h00; by_ready = 1'b0;
      #2;
      nChecks++;
      if ({r0, r1, s, y_valid, busy, y} !== 13'h0) begin
         nFail++;
         $display("[TB] FAIL reset_init: {r0,r1,s,y_valid,busy,y} got %h, expected 0000", {r0, r1, s, y_valid, busy, y});
      end
      applyReset();
      v1 = 1'b1; d1 = 8'h55; y_ready = 1'b1;
      repeat (3) tick();
      nChecks++;
      if ({s, busy, y_valid, y} !== {3'b111, 8'h55}) begin
         nFail++;
         $display("[TB] FAIL pre_reset_g1: {s,busy,y_valid,y} got %h, expected %h", {s, busy, y_valid, y}, {3'b111, 8'h55});
      end
      #2;
      reset_n = 1'b0;
      #1;
      nChecks++;
      if ({r0, r1, s, y_valid, busy, y} !== 13'h0) begin
         nFail++;
         $display("[TB] FAIL async_reset: {r0,r1,s,y_valid,busy,y} got %h, expected 0000", {r0, r1, s, y_valid, busy, y});
      end
   endtask

   task automatic test_single();
      applyReset();
      v0 = 1'b1; d0 = 8'hA5; y_ready = 1'b1;
      #1;
      nChecks++;
      if ({r0, busy} !== 2'b00) begin
         nFail++;
         $display("[TB] FAIL single_c0: {r0,busy} got %b, expected 00", {r0, busy});
      end
      @(posedge clk);
      #1;
      nChecks++;
      if ({r0, s, busy, y_valid} !== 4'b1010) begin
         nFail++;
         $display("[TB] FAIL single_c1: {r0,s,busy,y_valid} got %b, expected 1010", {r0, s, busy, y_valid});
      end
      @(posedge clk);
      #1;
      nChecks++;
      if ({y_valid, y} !== {1'b1, 8'hA5}) begin
         nFail++;
         $display("[TB] FAIL single_c2: {y_valid,y} got %h, expected %h", {y_valid, y}, {1'b1, 8'hA5});
      end
      v0 = 1'b0;
      @(posedge clk);
      #1;
      nChecks++;
      if ({y_valid, busy} !== 2'b00) begin
         nFail++;
         $display("[TB] FAIL single_c3: {y_valid,busy} got %b, expected 00", {y_valid, busy});
      end
   endtask

   task automatic test_rotation();
      logic [7:0] expRot [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                                 8'h04, 8'h05, 8'h06, 8'h07, 8'h84, 8'h85, 8'h86, 8'h87};
      applyReset();
      v0 = 1'b1; v1 = 1'b1; d0 = 8'h00; d1 = 8'h80; y_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (fire0) begin
            nChecks++;
            if (smpS !== 1'b0) begin
               nFail++;
               $display("[TB] FAIL rot_sel0 beat %h: s got %b, expected 0", d0, smpS);
            end
            d0 = d0 + 8'd1;
         end
         if (fire1) begin
            nChecks++;
            if (smpS !== 1'b1) begin
               nFail++;
               $display("[TB] FAIL rot_sel1 beat %h: s got %b, expected 1", d1, smpS);
            end
            d1 = d1 + 8'd1;
         end
      end
      nChecks++;
      if (outQ.size() < 16) begin
         nFail++;
         $display("[TB] FAIL rot_count: got %0d words, expected at least 16", outQ.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            nChecks++;
            if (outQ[i] !== expRot[i]) begin
               nFail++;
               $display("[TB] FAIL rot_word[%0d]: got %h, expected %h", i, outQ[i], expRot[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] expBp [9] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h90, 8'h91, 8'h92, 8'h93, 8'h14};
      applyReset();
      v0 = 1'b1; d0 = 8'h10; y_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (fire0) d0 = d0 + 8'd1;
      end
      y_ready = 1'b0; v1 = 1'b1; d1 = 8'h90;
      for (int c = 0; c < 5; c++) begin
         tick();
         nChecks++;
         if ({smpY, smpYValid, smpR0, smpR1, smpS} !== {8'h11, 4'b1000}) begin
            nFail++;
            $display("[TB] FAIL stall[%0d]: {y,y_valid,r0,r1,s} got %h, expected %h", c,
                     {smpY, smpYValid, smpR0, smpR1, smpS}, {8'h11, 4'b1000});
         end
      end
      y_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (fire0) d0 = d0 + 8'd1;
         if (fire1) d1 = d1 + 8'd1;
      end
      nChecks++;
      if (outQ.size() < 9) begin
         nFail++;
         $display("[TB] FAIL bp_count: got %0d words, expected at least 9", outQ.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            nChecks++;
            if (outQ[i] !== expBp[i]) begin
               nFail++;
               $display("[TB] FAIL bp_word[%0d]: got %h, expected %h", i, outQ[i], expBp[i]);
            end
         end
      end
   endtask

   task automatic test_early_switch();
      logic [7:0] expEs [7] = '{8'h20, 8'h21, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h22};
      applyReset();
      v0 = 1'b1; v1 = 1'b1; d0 = 8'h20; d1 = 8'hA0; y_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (fire0) d0 = d0 + 8'd1;
      end
      v0 = 1'b0;
      tick();
      nChecks++;
      if ({s, r1, r0} !== 3'b110) begin
         nFail++;
         $display("[TB] FAIL early_switch: {s,r1,r0} got %b, expected 110", {s, r1, r0});
      end
      v0 = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (fire0) d0 = d0 + 8'd1;
         if (fire1) d1 = d1 + 8'd1;
      end
      nChecks++;
      if (outQ.size() < 7) begin
         nFail++;
         $display("[TB] FAIL es_count: got %0d words, expected at least 7", outQ.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            nChecks++;
            if (outQ[i] !== expEs[i]) begin
               nFail++;
               $display("[TB] FAIL es_word[%0d]: got %h, expected %h", i, outQ[i], expEs[i]);
            end
         end
      end
   endtask

   task automatic test_first_grant_and_burst1();
      logic [7:0] expB1 [6] = '{8'h30, 8'hC0, 8'h31, 8'hC1, 8'h32, 8'hC2};
      applyReset();
      v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'hC3; y_ready = 1'b1;
      tick();
      nChecks++;
      if ({r0, r1, s} !== 3'b100) begin
         nFail++;
         $display("[TB] FAIL tie_grant: {r0,r1,s} got %b, expected 100", {r0, r1, s});
      end
      tick();
      nChecks++;
      if ({y_valid, y} !== {1'b1, 8'h3C}) begin
         nFail++;
         $display("[TB] FAIL tie_first_word: {y_valid,y} got %h, expected %h", {y_valid, y}, {1'b1, 8'h3C});
      end
      applyReset();
      bv0 = 1'b1; bv1 = 1'b1; bd0 = 8'h30; bd1 = 8'hC0; by_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         tick();
         if (bfire0) bd0 = bd0 + 8'd1;
         if (bfire1) bd1 = bd1 + 8'd1;
      end
      nChecks++;
      if (boutQ.size() < 6) begin
         nFail++;
         $display("[TB] FAIL b1_count: got %0d words, expected at least 6", boutQ.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            nChecks++;
            if (boutQ[i] !== expB1[i]) begin
               nFail++;
               $display("[TB] FAIL b1_word[%0d]: got %h, expected %h", i, boutQ[i], expB1[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_early_switch();
      test_first_grant_and_burst1();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
